// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART character transmitter among N_REQ requesters. Requesters
//   are served round-robin. A requester whose char is not flagged as the last
//   of its packet keeps the grant (packet lock) until it sends its last char,
//   or until it leaves its request low for HOLD_MAX cycles.
//
// Ports
//   i_clk        system clock
//   i_rst        asynchronous reset, active-low
//   i_req        per-requester "char ready"
//   i_char       8-bit char of requester k in bits [8k+7:8k]
//   i_last       per-requester "this char ends the packet"
//   o_ack        one-cycle pulse, char of the granted requester was taken
//   o_grant_idx  index of the current / last granted requester
//   o_tx_char    char to the transmitter, stable from o_tx_start to i_tx_done
//   o_tx_start   one-cycle transmit command
//   i_tx_done    one-cycle pulse from the transmitter after the stop bit
//   o_busy       high whenever the arbiter is not idle
module uart_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 2400
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [8*N_REQ-1:0] i_char,
    input  logic [N_REQ-1:0]   i_last,
    output logic [N_REQ-1:0]   o_ack,
    output logic [2:0]         o_grant_idx,
    output logic [7:0]         o_tx_char,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy
);

    localparam int HW = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;

    state_t state, state_nxt;

    logic [2:0]            rr_ptr, rr_d;
    logic                  last_flag, last_d;
    logic [HW-1:0]         hold_cnt, hold_d;
    logic [2:0]            idx_d;
    logic [7:0]            char_d;
    logic [N_REQ-1:0]      ack_d;
    logic                  start_d, busy_d;

    logic [N_REQ-1:0][7:0] char_arr;
    logic                  pick_found;
    logic [2:0]            pick_idx;
    logic [2:0]            tgt;
    logic                  sel_req, sel_last;
    logic [7:0]            sel_char;
    logic                  latch, release_lock;

    assign char_arr = i_char;

    // Round-robin search: distance of requester j from rr_ptr (mod N_REQ).
    // Walking distances from largest to smallest leaves the nearest hit.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (i_req[j] &&
                    (((j >= int'(rr_ptr)) ? (j - int'(rr_ptr))
                                          : (j + N_REQ - int'(rr_ptr))) == i)) begin
                    pick_found = 1'b1;
                    pick_idx   = 3'(j);
                end
            end
        end
    end

    // In IDLE the candidate is the round-robin pick; otherwise the lock owner.
    assign tgt = (state == IDLE) ? pick_idx : o_grant_idx;

    always_comb begin
        sel_req  = 1'b0;
        sel_last = 1'b0;
        sel_char = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (3'(j) == tgt) begin
                sel_req  = i_req[j];
                sel_last = i_last[j];
                sel_char = char_arr[j];
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_found) state_nxt = SEND;
            SEND: state_nxt = WAIT;
            WAIT: begin
                if (i_tx_done) begin
                    if (last_flag)    state_nxt = IDLE;
                    else if (sel_req) state_nxt = SEND;
                    else              state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (sel_req)                             state_nxt = SEND;
                else if (hold_cnt == HW'(HOLD_MAX - 1))  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values. Every entry into SEND latches a char,
    // whether it comes from IDLE, WAIT or HOLD.
    always_comb begin
        latch        = (state_nxt == SEND);
        release_lock = ((state == WAIT) || (state == HOLD)) && (state_nxt == IDLE);

        idx_d   = latch ? tgt      : o_grant_idx;
        char_d  = latch ? sel_char : o_tx_char;
        last_d  = latch ? sel_last : last_flag;
        start_d = latch;
        busy_d  = (state_nxt != IDLE);
        hold_d  = (state == HOLD) ? hold_cnt + 1'b1 : '0;

        for (int j = 0; j < N_REQ; j++) ack_d[j] = latch && (3'(j) == tgt);

        rr_d = rr_ptr;
        if (release_lock)
            rr_d = (o_grant_idx == 3'(N_REQ - 1)) ? 3'd0 : o_grant_idx + 3'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rr_ptr      <= '0;
            last_flag   <= 1'b0;
            hold_cnt    <= '0;
            o_grant_idx <= '0;
            o_tx_char   <= '0;
            o_ack       <= '0;
            o_tx_start  <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            rr_ptr      <= rr_d;
            last_flag   <= last_d;
            hold_cnt    <= hold_d;
            o_grant_idx <= idx_d;
            o_tx_char   <= char_d;
            o_ack       <= ack_d;
            o_tx_start  <= start_d;
            o_busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int HM = 2400;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   last = '0;
    logic [8*N-1:0] chr = '0;
    logic           done = 1'b0;
    logic [N-1:0]   ack;
    logic [2:0]     gidx;
    logic [7:0]     txc;
    logic           txs;
    logic           busy;

    int vectors     = 0;
    int miscompares = 0;
    int n_start     = 0;
    int tx_delay    = 10;
    int tx_cnt      = -1;

    logic [8:0]  rq [N][$];   // per-requester pending {last, char}
    logic [10:0] expq[$];     // expected grants {idx, char}
    logic [10:0] mon_e;
    logic [N-1:0] mon_ack;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .HOLD_MAX(HM)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_char(chr), .i_last(last),
        .o_ack(ack), .o_grant_idx(gidx), .o_tx_char(txc), .o_tx_start(txs),
        .i_tx_done(done), .o_busy(busy)
    );

    // Requester model: pop on ack, present head of queue.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (ack[k] && rq[k].size() > 0) void'(rq[k].pop_front());
            req[k] = (rq[k].size() > 0);
            if (rq[k].size() > 0) begin
                chr[8*k +: 8] = rq[k][0][7:0];
                last[k]       = rq[k][0][8];
            end
        end
    end

    // Transmitter model: done pulse tx_delay cycles after start.
    initial forever begin
        @(negedge clk);
        done = 1'b0;
        if (tx_cnt == 0) begin
            done   = 1'b1;
            tx_cnt = -1;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
        end
        if (txs) tx_cnt = tx_delay - 1;
    end

    // Scoreboard monitor
    initial forever begin
        @(negedge clk);
        if (txs) begin
            n_start++;
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL grant: unexpected start idx=%0d char=%h", gidx, txc);
            end else begin
                mon_e   = expq.pop_front();
                mon_ack = N'(1) << mon_e[10:8];
                if ({ack, gidx, txc} !== {mon_ack, mon_e}) begin
                    miscompares++;
                    $display("FAIL grant: got ack=%b idx=%0d char=%h want ack=%b idx=%0d char=%h",
                             ack, gidx, txc, mon_ack, mon_e[10:8], mon_e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_req(input int k, input logic l, input logic [7:0] c);
        rq[k].push_back({l, c});
    endtask

    task automatic push_exp(input int k, input logic [7:0] c);
        expq.push_back({3'(k), c});
    endtask

    task automatic wait_start(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            if (txs) ok = 1;
        end
        check("start_timeout", 32'(ok), 1);
    endtask

    // Returns at the posedge on which the DUT samples done.
    task automatic wait_done(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            if (done) ok = 1;
        end
        check("done_timeout", 32'(ok), 1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        bit pend;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            pend = 0;
            for (int k = 0; k < N; k++) if (rq[k].size() > 0) pend = 1;
            if (!busy && !pend && expq.size() == 0) ok = 1;
        end
        check("idle_timeout", 32'(ok), 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2; rst = 1'b0;
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2;
    endtask

    initial begin
        int cnt;
        int s0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", 32'({ack, gidx, txc, txs, busy}), 0);
        #1 rst = 1'b1;
        @(posedge clk); #2;

        // Single char, long transmit
        tx_delay = 200;
        push_req(0, 1'b1, 8'h41); push_exp(0, 8'h41);
        @(posedge clk); #1;
        check("single_latency", 32'({txs, ack, txc}), 32'({1'b1, 4'b0001, 8'h41}));
        wait_done(300); #1;
        check("single_idle_after_done", 32'(busy), 0);
        tx_delay = 10;

        // Round-robin from rr_ptr=0
        do_reset();
        for (int k = 0; k < N; k++) push_req(k, 1'b1, 8'h10 + 8'(k));
        push_req(0, 1'b1, 8'h20);
        push_exp(0, 8'h10); push_exp(1, 8'h11); push_exp(2, 8'h12);
        push_exp(3, 8'h13); push_exp(0, 8'h20);
        wait_idle(500);

        // Packet lock: rr_ptr=1, requester 2 packet, requester 0 waiting
        push_req(2, 1'b0, 8'h48); push_req(2, 1'b0, 8'h49); push_req(2, 1'b1, 8'h0A);
        push_req(0, 1'b1, 8'h30);
        push_exp(2, 8'h48); push_exp(2, 8'h49); push_exp(2, 8'h0A); push_exp(0, 8'h30);
        wait_idle(500);

        // HOLD timeout: rr_ptr=1
        push_req(1, 1'b0, 8'h55); push_exp(1, 8'h55);
        wait_done(100); #1;
        cnt = 0;
        while (busy && cnt < HM + 20) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("hold_busy_cycles", 32'(cnt), 32'(HM));
        check("hold_released", 32'(busy), 0);
        s0 = n_start;
        repeat (50) @(posedge clk); #1;
        check("hold_no_restart", 32'(n_start), 32'(s0));

        // After release rr_ptr=2: 2 beats 1
        push_req(1, 1'b1, 8'h61); push_req(2, 1'b1, 8'h62);
        push_exp(2, 8'h62); push_exp(1, 8'h61);
        wait_idle(500);

        // HOLD resume: rr_ptr=2, only requester 1 active
        push_req(1, 1'b0, 8'h55); push_exp(1, 8'h55);
        wait_done(100);
        repeat (100) @(posedge clk); #1;
        check("resume_still_holding", 32'(busy), 1);
        push_req(1, 1'b1, 8'h56); push_exp(1, 8'h56);
        @(posedge clk); #1;
        check("resume_latency", 32'({txs, ack, txc}), 32'({1'b1, 4'b0010, 8'h56}));
        wait_idle(500);

        // Async reset in WAIT
        tx_delay = 50;
        push_req(3, 1'b0, 8'h77); push_exp(3, 8'h77);
        wait_start(20);
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset_outputs", 32'({ack, gidx, txc, txs, busy}), 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        s0 = n_start;
        wait_done(100);
        repeat (5) @(posedge clk); #1;
        check("stale_done_busy", 32'(busy), 0);
        check("stale_done_no_start", 32'(n_start), 32'(s0));
        tx_delay = 10;
        push_req(0, 1'b1, 8'h80); push_req(2, 1'b1, 8'h82);
        push_exp(0, 8'h80); push_exp(2, 8'h82);
        wait_idle(500);

        check("scoreboard_drained", 32'(expq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
